// File: rtl/km_link_pkg.sv
`default_nettype none
// ============================================================================
// km_link_pkg : shared types and constants for the KMBox link scheduler
// Revision    : 1.0
// ============================================================================
package km_link_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CMD  = 2'd1,
    SRC_STAT = 2'd2,
    SRC_PING = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RX = 2'd2
  } state_e;

  localparam logic [63:0] PING_PKT_DEFAULT = 64'h0000_0000_0000_00FE;

  // A top byte of all-zeros or all-ones means MISO is stuck, not a live peer.
  function automatic logic is_good_reply(input logic [63:0] data);
    return (data[63:56] != 8'h00) && (data[63:56] != 8'hFF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/km_link_scheduler_sat_timer.sv
`default_nettype none
// ============================================================================
// sat_timer : saturating up-counter with clear and terminal-count flag
// Revision  : 1.0
// ============================================================================
module sat_timer #(
  parameter int unsigned LIMIT = 15,
  parameter int unsigned W     = $clog2(LIMIT + 2)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [W-1:0] TERM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == TERM);

endmodule
`default_nettype wire

// File: rtl/km_link_scheduler.sv
`default_nettype none
// ============================================================================
// km_link_scheduler : arbitrates cmd / stat / ping packets onto one SPI master
// Revision          : 1.0
// ============================================================================
module km_link_scheduler
  import km_link_pkg::*;
#(
  parameter int unsigned PING_INTERVAL = 96_000_000,
  parameter int unsigned TIMEOUT_CLKS  = 240_000_000,
  parameter int unsigned RX_TIMEOUT    = 4096,
  parameter int unsigned MAX_BURST     = 8,
  parameter logic [63:0] PING_PKT      = PING_PKT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] stat_data,
  input  logic        stat_valid,
  output logic        stat_ready,
  output logic [63:0] stat_rsp_data,
  output logic        stat_rsp_valid,
  output logic [63:0] km_tx_data,
  output logic        km_tx_valid,
  input  logic        km_tx_ready,
  input  logic [63:0] km_rx_data,
  input  logic        km_rx_valid,
  output logic [63:0] resp_data,
  output logic        connected,
  output logic        activity,
  output logic [1:0]  grant_src,
  output logic [7:0]  rx_err_cnt
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  state_e      state_q, state_d;
  src_e        owner_q, owner_d;
  src_e        win;
  logic [63:0] data_q, data_d;
  logic [63:0] resp_q, resp_d;
  logic [63:0] srsp_q, srsp_d;
  logic        srsp_vld_q, srsp_vld_d;
  logic [BW-1:0] burst_q, burst_d;
  logic        ping_pending_q, ping_pending_d;
  logic        connected_q, connected_d;
  logic [7:0]  err_q, err_d;

  logic ping_done;
  logic live_done;
  logic rx_done;
  logic rx_good;
  logic accept;

  assign accept  = (state_q == ST_ISSUE) && km_tx_ready;
  assign rx_good = (state_q == ST_WAIT_RX) && km_rx_valid && is_good_reply(km_rx_data);

  sat_timer #(.LIMIT(PING_INTERVAL - 1), .W($clog2(PING_INTERVAL + 1))) u_ping_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (1'b1),
    .done_o (ping_done)
  );

  sat_timer #(.LIMIT(TIMEOUT_CLKS - 1), .W($clog2(TIMEOUT_CLKS + 1))) u_live_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rx_good),
    .en_i   (1'b1),
    .done_o (live_done)
  );

  sat_timer #(.LIMIT(RX_TIMEOUT - 1), .W($clog2(RX_TIMEOUT + 1))) u_rx_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != ST_WAIT_RX),
    .en_i   (1'b1),
    .done_o (rx_done)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    data_d         = data_q;
    resp_d         = resp_q;
    srsp_d         = srsp_q;
    srsp_vld_d     = 1'b0;
    burst_d        = burst_q;
    ping_pending_d = ping_pending_q;
    connected_d    = connected_q;
    err_d          = err_q;
    cmd_ready      = 1'b0;
    stat_ready     = 1'b0;
    km_tx_valid    = 1'b0;
    activity       = 1'b0;
    win            = SRC_NONE;

    // Only arm the ping while idle so an expiry during a stalled ISSUE cannot
    // queue a redundant ping behind a transfer that is about to reset the timer.
    if (ping_done && (state_q == ST_IDLE)) ping_pending_d = 1'b1;

    if (rx_good) begin
      connected_d = 1'b1;
    end else if (live_done) begin
      connected_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (stat_valid && (burst_q == BURST_MAX)) win = SRC_STAT;
        else if (cmd_valid)                       win = SRC_CMD;
        else if (stat_valid)                      win = SRC_STAT;
        else if (ping_pending_q)                  win = SRC_PING;

        if (win == SRC_CMD) begin
          cmd_ready = 1'b1;
          data_d    = cmd_data;
        end else if (win == SRC_STAT) begin
          stat_ready = 1'b1;
          data_d     = stat_data;
        end else if (win == SRC_PING) begin
          data_d         = PING_PKT;
          ping_pending_d = 1'b0;
        end

        if (win != SRC_NONE) begin
          owner_d = win;
          state_d = ST_ISSUE;
        end

        if ((win == SRC_STAT) || !stat_valid) begin
          burst_d = '0;
        end else if ((win == SRC_CMD) && (burst_q != BURST_MAX)) begin
          burst_d = burst_q + BW'(1);
        end
      end

      ST_ISSUE: begin
        km_tx_valid = 1'b1;
        if (km_tx_ready) begin
          activity = 1'b1;
          state_d  = ST_WAIT_RX;
        end
      end

      ST_WAIT_RX: begin
        // A reply arriving on the expiry cycle still wins over the timeout.
        if (km_rx_valid) begin
          if (owner_q == SRC_STAT) begin
            srsp_d     = km_rx_data;
            srsp_vld_d = 1'b1;
          end else begin
            resp_d = km_rx_data;
          end
          owner_d = SRC_NONE;
          state_d = ST_IDLE;
        end else if (rx_done) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          owner_d = SRC_NONE;
          state_d = ST_IDLE;
        end
      end

      default: begin
        owner_d = SRC_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      owner_q        <= SRC_NONE;
      data_q         <= '0;
      resp_q         <= '0;
      srsp_q         <= '0;
      srsp_vld_q     <= 1'b0;
      burst_q        <= '0;
      ping_pending_q <= 1'b0;
      connected_q    <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      data_q         <= data_d;
      resp_q         <= resp_d;
      srsp_q         <= srsp_d;
      srsp_vld_q     <= srsp_vld_d;
      burst_q        <= burst_d;
      ping_pending_q <= ping_pending_d;
      connected_q    <= connected_d;
      err_q          <= err_d;
    end
  end

  assign km_tx_data     = data_q;
  assign resp_data      = resp_q;
  assign stat_rsp_data  = srsp_q;
  assign stat_rsp_valid = srsp_vld_q;
  assign connected      = connected_q;
  assign grant_src      = owner_q;
  assign rx_err_cnt     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_km_link_scheduler.sv
`default_nettype none
// ============================================================================
// tb_km_link_scheduler : directed + randomized bench with a timestamp model
// Revision             : 1.0
// ============================================================================
module tb_km_link_scheduler;

  localparam int unsigned PI   = 100;
  localparam int unsigned TO   = 400;
  localparam int unsigned RXTO = 16;
  localparam int unsigned MB   = 8;
  localparam logic [63:0] PING_EXP = 64'h0000_0000_0000_00FE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] stat_data = '0;
  logic        stat_valid = 1'b0;
  logic        stat_ready;
  logic [63:0] stat_rsp_data;
  logic        stat_rsp_valid;
  logic [63:0] km_tx_data;
  logic        km_tx_valid;
  logic        km_tx_ready = 1'b0;
  logic [63:0] km_rx_data = '0;
  logic        km_rx_valid = 1'b0;
  logic [63:0] resp_data;
  logic        connected;
  logic        activity;
  logic [1:0]  grant_src;
  logic [7:0]  rx_err_cnt;

  km_link_scheduler #(
    .PING_INTERVAL(PI), .TIMEOUT_CLKS(TO), .RX_TIMEOUT(RXTO), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .stat_data(stat_data), .stat_valid(stat_valid), .stat_ready(stat_ready),
    .stat_rsp_data(stat_rsp_data), .stat_rsp_valid(stat_rsp_valid),
    .km_tx_data(km_tx_data), .km_tx_valid(km_tx_valid), .km_tx_ready(km_tx_ready),
    .km_rx_data(km_rx_data), .km_rx_valid(km_rx_valid),
    .resp_data(resp_data), .connected(connected), .activity(activity),
    .grant_src(grant_src), .rx_err_cnt(rx_err_cnt)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  longint      cyc      = 0;
  int          m_burst, m_err;
  bit          m_have_good;
  longint      m_last_good;
  logic [63:0] m_resp, m_stat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit good_reply(input logic [63:0] d);
    return (d[63:56] != 8'h00) && (d[63:56] != 8'hFF);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic exp_connected();
    return m_have_good && ((cyc - m_last_good) < longint'(TO));
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; stat_valid = 1'b0; km_tx_ready = 1'b0; km_rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    m_burst = 0; m_err = 0; m_have_good = 1'b0; m_last_good = 0;
    m_resp = '0; m_stat = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_valid"}, km_tx_valid, 1'b0);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    check({tag, "_stat_ready"}, stat_ready, 1'b0);
    check({tag, "_rsp_valid"}, stat_rsp_valid, 1'b0);
    check({tag, "_activity"}, activity, 1'b0);
    check({tag, "_connected"}, connected, 1'b0);
    check({tag, "_grant_src"}, grant_src, 2'd0);
    check({tag, "_rx_err"}, rx_err_cnt, 8'd0);
    check({tag, "_resp"}, resp_data, 64'd0);
    check({tag, "_stat_rsp"}, stat_rsp_data, 64'd0);
    check({tag, "_tx_data"}, km_tx_data, 64'd0);
  endtask

  // Called in an idle cycle with the requests already driven; runs one whole
  // transaction with the given ready delay, reply delay and reply payload.
  task automatic serve(input int txd, input int rxd, input logic [63:0] rxv, output int src);
    logic [63:0] exp_data;
    logic        sv;
    sv = stat_valid;
    if (stat_valid && (m_burst == MB)) src = 2;
    else if (cmd_valid)                src = 1;
    else if (stat_valid)               src = 2;
    else                               src = 3;
    exp_data = (src == 1) ? cmd_data : (src == 2) ? stat_data : PING_EXP;
    #1;
    check("cmd_ready", cmd_ready, src == 1);
    check("stat_ready", stat_ready, src == 2);
    if ((src == 2) || !sv) m_burst = 0;
    else if ((src == 1) && (m_burst < MB)) m_burst++;
    tick();
    if (src == 1) cmd_valid = 1'b0;
    if (src == 2) stat_valid = 1'b0;
    check("grant_src", grant_src, src);
    check("tx_valid", km_tx_valid, 1'b1);
    check("tx_data", km_tx_data, exp_data);
    check("rsp_pulse_len", stat_rsp_valid, 1'b0);
    for (int i = 0; i < txd; i++) begin
      tick();
      check("tx_hold", km_tx_data, exp_data);
      check("activity_wait", activity, 1'b0);
    end
    km_tx_ready = 1'b1;
    #1;
    check("activity", activity, 1'b1);
    tick();
    km_tx_ready = 1'b0;
    if (rxd < int'(RXTO)) begin
      for (int i = 0; i < rxd; i++) tick();
      km_rx_data  = rxv;
      km_rx_valid = 1'b1;
      tick();
      km_rx_valid = 1'b0;
      if (src == 2) m_stat = rxv;
      else          m_resp = rxv;
      check("stat_rsp_valid", stat_rsp_valid, src == 2);
      if (good_reply(rxv)) begin
        m_have_good = 1'b1;
        m_last_good = cyc;
      end
    end else begin
      for (int i = 0; i < int'(RXTO) - 1; i++) tick();
      check("rx_wait_held", grant_src, src);
      tick();
      if (m_err < 255) m_err++;
      check("rsp_on_timeout", stat_rsp_valid, 1'b0);
    end
    check("grant_idle", grant_src, 2'd0);
    check("resp_data", resp_data, m_resp);
    check("stat_rsp_data", stat_rsp_data, m_stat);
    check("rx_err_cnt", rx_err_cnt, m_err[7:0]);
    check("connected", connected, exp_connected());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     src;
    longint acc;
    logic [63:0] rv;

    // Reset state
    do_reset();
    check_reset_values("reset");

    // Single cmd, ready three cycles late
    cmd_data  = 64'h0123_4567_89AB_CDEF;
    cmd_valid = 1'b1;
    serve(3, 2, 64'hA5A5_A5A5_A5A5_A5A5, src);
    check("single_resp", resp_data, 64'hA5A5_A5A5_A5A5_A5A5);
    check("single_conn", connected, 1'b1);

    // Contention: 8 cmd grants, then 1 stat, repeating
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (!cmd_valid)  begin cmd_valid  = 1'b1; cmd_data  = rnd64(); end
      if (!stat_valid) begin stat_valid = 1'b1; stat_data = rnd64(); end
      serve($urandom_range(0, 2), $urandom_range(0, 5), {8'h5A, 56'(rnd64())}, src);
      check("contention_order", src, ((i % 9) == 8) ? 2 : 1);
    end

    // Randomized traffic: mixed sources, delays, timeouts and stuck-bus replies
    for (int i = 0; i < 60; i++) begin
      if (!cmd_valid && ($urandom_range(0, 1) == 1)) begin cmd_valid = 1'b1; cmd_data = rnd64(); end
      if (!stat_valid && ($urandom_range(0, 1) == 1)) begin stat_valid = 1'b1; stat_data = rnd64(); end
      if (!cmd_valid && !stat_valid) begin cmd_valid = 1'b1; cmd_data = rnd64(); end
      rv = rnd64();
      case ($urandom_range(0, 3))
        0: rv[63:56] = 8'h00;
        1: rv[63:56] = 8'hFF;
        default: ;
      endcase
      serve($urandom_range(0, 3), $urandom_range(0, 19), rv, src);
    end

    // Idle ping and its repeat interval
    do_reset();
    while (!km_tx_valid && (cyc < 200)) tick();
    check("ping_first_cycle", cyc, 64'd101);
    check("ping_data", km_tx_data, PING_EXP);
    check("ping_src", grant_src, 2'd3);
    km_tx_ready = 1'b1;
    tick();
    km_tx_ready = 1'b0;
    acc = cyc;
    km_rx_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    km_rx_valid = 1'b1;
    tick();
    km_rx_valid = 1'b0;
    while (!km_tx_valid && (cyc < acc + 200)) tick();
    check("ping_repeat_gap", cyc - acc, 64'd101);
    check("ping_repeat_data", km_tx_data, PING_EXP);

    // Liveness: stuck-bus replies never connect; one good reply then silence
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = rnd64();
      serve(0, 1, (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h00FF_0000_1234_0000, src);
    end
    check("live_stuck", connected, 1'b0);
    cmd_valid = 1'b1;
    cmd_data  = rnd64();
    serve(0, 1, 64'h3C00_0000_0000_0001, src);
    while (cyc < m_last_good + longint'(TO) - 1) tick();
    check("live_last_cycle", connected, 1'b1);
    tick();
    check("live_dropped", connected, 1'b0);

    // RX timeout, reply on the expiry cycle, then saturation
    do_reset();
    cmd_valid = 1'b1;
    cmd_data  = rnd64();
    serve(0, 20, 64'h0, src);
    check("rxto_first", rx_err_cnt, 8'd1);
    cmd_valid = 1'b1;
    cmd_data  = rnd64();
    serve(0, int'(RXTO) - 1, 64'h7700_0000_0000_0042, src);
    check("rxto_edge_reply", resp_data, 64'h7700_0000_0000_0042);
    for (int i = 0; i < 299; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = rnd64();
      tick();
      cmd_valid   = 1'b0;
      km_tx_ready = 1'b1;
      tick();
      km_tx_ready = 1'b0;
      repeat (RXTO) tick();
    end
    m_err = (m_err + 299 > 255) ? 255 : m_err + 299;
    check("rxto_saturated", rx_err_cnt, m_err[7:0]);

    // Asynchronous reset during ISSUE
    cmd_valid = 1'b1;
    cmd_data  = 64'hDEAD_BEEF_0000_1111;
    tick();
    cmd_valid = 1'b0;
    check("pre_reset_issue", km_tx_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async");
    do_reset();
    cmd_valid = 1'b1;
    cmd_data  = 64'hCAFE_0000_0000_0007;
    serve(1, 3, 64'h9900_0000_0000_0009, src);
    check("post_reset_resp", resp_data, 64'h9900_0000_0000_0009);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
